// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    MEM_WAIT   = 2'd2,
    HALT       = 2'd3
  } state_e;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_EX = 2'b01;
  localparam logic [1:0] FWD_WB = 2'b10;

endpackage

// File: rtl/pipe_fwd_unit.sv
// Operand bypass select for one source register; EX match beats WB match.
module pipe_fwd_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] i_rs,
  input  logic [REG_AW-1:0] i_ex_rd,
  input  logic              i_ex_reg_write,
  input  logic              i_ex_is_load,
  input  logic [REG_AW-1:0] i_wb_rd,
  input  logic              i_wb_reg_write,
  output logic [1:0]        o_fwd
);

  logic w_ex_hit;
  logic w_wb_hit;

  // A load in EX has no data yet; the load-use stall covers that case.
  assign w_ex_hit = i_ex_reg_write && (i_ex_rd != '0) && (i_ex_rd == i_rs) && !i_ex_is_load;
  assign w_wb_hit = i_wb_reg_write && (i_wb_rd != '0) && (i_wb_rd == i_rs);

  always_comb begin
    o_fwd = FWD_RF;
    if (w_ex_hit)      o_fwd = FWD_EX;
    else if (w_wb_hit) o_fwd = FWD_WB;
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Five-stage pipeline control: stall/flush/freeze/halt sequencing plus operand forwarding.
module pipeline_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_uses_rs1,
  input  logic              id_uses_rs2,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_reg_write,
  input  logic              ex_is_load,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_reg_write,
  input  logic              ex_redirect,
  input  logic              dmem_req,
  input  logic              dmem_ack,
  input  logic              tohost_we,
  input  logic [31:0]       tohost_data,
  output logic              pc_en,
  output logic              id_en,
  output logic              ex_en,
  output logic              wb_en,
  output logic              id_flush,
  output logic              ex_flush,
  output logic              pc_sel,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              halted,
  output logic [CNT_W-1:0]  stall_count
);

  state_e             r_state;
  state_e             w_next;
  logic [CNT_W-1:0]   r_stall_cnt;
  logic               w_load_use;
  logic               w_freeze;
  logic               w_halt_evt;

  assign w_load_use = ex_is_load && ex_reg_write && (ex_rd != '0) &&
                      (((ex_rd == id_rs1) && id_uses_rs1) ||
                       ((ex_rd == id_rs2) && id_uses_rs2));
  assign w_freeze   = dmem_req && !dmem_ack;
  assign w_halt_evt = tohost_we && (tohost_data != '0);

  always_ff @(posedge clk) begin
    if (rst) r_state <= RUN;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    pc_en    = 1'b1;
    id_en    = 1'b1;
    ex_en    = 1'b1;
    wb_en    = 1'b1;
    id_flush = 1'b0;
    ex_flush = 1'b0;
    pc_sel   = 1'b0;
    case (r_state)
      RUN: begin
        if (w_freeze) begin
          {pc_en, id_en, ex_en, wb_en} = 4'b0000;
          w_next = MEM_WAIT;
        end else if (ex_redirect) begin
          pc_sel   = 1'b1;
          id_flush = 1'b1;
          ex_flush = 1'b1;
        end else if (w_load_use) begin
          pc_en    = 1'b0;
          id_en    = 1'b0;
          ex_flush = 1'b1;
          w_next   = LOAD_STALL;
        end
      end
      LOAD_STALL: begin
        // The load has already been separated by one bubble; never stall on it again.
        if (w_freeze) begin
          {pc_en, id_en, ex_en, wb_en} = 4'b0000;
          w_next = MEM_WAIT;
        end else begin
          if (ex_redirect) begin
            pc_sel   = 1'b1;
            id_flush = 1'b1;
            ex_flush = 1'b1;
          end
          w_next = RUN;
        end
      end
      MEM_WAIT: begin
        if (!dmem_ack) begin
          {pc_en, id_en, ex_en, wb_en} = 4'b0000;
        end else begin
          if (ex_redirect) begin
            pc_sel   = 1'b1;
            id_flush = 1'b1;
            ex_flush = 1'b1;
          end
          w_next = RUN;
        end
      end
      HALT: begin
        {pc_en, id_en, ex_en, wb_en} = 4'b0000;
      end
      default: w_next = RUN;
    endcase
    // Halt wins over every other next-state decision.
    if (r_state != HALT && w_halt_evt) w_next = HALT;
  end

  always_ff @(posedge clk) begin
    if (rst)
      r_stall_cnt <= '0;
    else if (!pc_en && r_state != HALT && r_stall_cnt != '1)
      r_stall_cnt <= r_stall_cnt + 1'b1;
  end

  assign halted      = (r_state == HALT);
  assign stall_count = r_stall_cnt;

  pipe_fwd_unit #(.REG_AW(REG_AW)) u_fwd_a (
    .i_rs           (id_rs1),
    .i_ex_rd        (ex_rd),
    .i_ex_reg_write (ex_reg_write),
    .i_ex_is_load   (ex_is_load),
    .i_wb_rd        (wb_rd),
    .i_wb_reg_write (wb_reg_write),
    .o_fwd          (fwd_a)
  );

  pipe_fwd_unit #(.REG_AW(REG_AW)) u_fwd_b (
    .i_rs           (id_rs2),
    .i_ex_rd        (ex_rd),
    .i_ex_reg_write (ex_reg_write),
    .i_ex_is_load   (ex_is_load),
    .i_wb_rd        (wb_rd),
    .i_wb_reg_write (wb_reg_write),
    .o_fwd          (fwd_b)
  );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: inputs change on negedge, outputs sampled 1ns later.
module tb_pipeline_ctrl;

  logic        clk;
  logic        rst;
  logic [4:0]  id_rs1, id_rs2, ex_rd, wb_rd;
  logic        id_uses_rs1, id_uses_rs2;
  logic        ex_reg_write, ex_is_load, wb_reg_write;
  logic        ex_redirect, dmem_req, dmem_ack, tohost_we;
  logic [31:0] tohost_data;
  logic        pc_en, id_en, ex_en, wb_en, id_flush, ex_flush, pc_sel, halted;
  logic [1:0]  fwd_a, fwd_b;
  logic [31:0] stall_count;

  int n_chk = 0;
  int n_bad = 0;

  pipeline_ctrl #(.REG_AW(5), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_is_load(ex_is_load),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .ex_redirect(ex_redirect), .dmem_req(dmem_req), .dmem_ack(dmem_ack),
    .tohost_we(tohost_we), .tohost_data(tohost_data),
    .pc_en(pc_en), .id_en(id_en), .ex_en(ex_en), .wb_en(wb_en),
    .id_flush(id_flush), .ex_flush(ex_flush), .pc_sel(pc_sel),
    .fwd_a(fwd_a), .fwd_b(fwd_b),
    .halted(halted), .stall_count(stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Advance to the next negedge (the posedge in between updates state).
  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle();
    id_rs1 = '0; id_rs2 = '0; id_uses_rs1 = 0; id_uses_rs2 = 0;
    ex_rd = '0; ex_reg_write = 0; ex_is_load = 0;
    wb_rd = '0; wb_reg_write = 0;
    ex_redirect = 0; dmem_req = 0; dmem_ack = 0;
    tohost_we = 0; tohost_data = '0;
  endtask

  task automatic do_reset();
    step(); rst = 1; idle();
    step(); rst = 0;
  endtask

  task automatic load_use_rs1_x5();
    ex_is_load = 1; ex_reg_write = 1; ex_rd = 5'd5;
    id_rs1 = 5'd5; id_uses_rs1 = 1;
  endtask

  function automatic logic [3:0] ens();
    return {pc_en, id_en, ex_en, wb_en};
  endfunction

  initial begin
    rst = 1; idle();
    step(); step();
    rst = 0;

    // Reset state
    #1;
    chk("rst_en",     {28'd0, ens()}, 32'hF);
    chk("rst_flush",  {30'd0, id_flush, ex_flush}, 32'd0);
    chk("rst_pcsel",  {31'd0, pc_sel}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_cnt",    stall_count, 32'd0);

    // Load-use on rs1, then the load is in WB while EX still shows it (no 2nd bubble)
    step(); load_use_rs1_x5(); #1;
    chk("lu_en",     {28'd0, ens()}, 32'h3);
    chk("lu_flush",  {30'd0, id_flush, ex_flush}, 32'd1);
    chk("lu_fwd_a",  {30'd0, fwd_a}, 32'd0);
    step(); wb_rd = 5'd5; wb_reg_write = 1; #1;
    chk("ls_en",     {28'd0, ens()}, 32'hF);
    chk("ls_flush",  {30'd0, id_flush, ex_flush}, 32'd0);
    chk("ls_fwd_a",  {30'd0, fwd_a}, 32'd2);
    chk("ls_cnt",    stall_count, 32'd1);
    step(); idle(); #1;
    chk("ls_cnt2",   stall_count, 32'd1);

    // Redirect overrides load-use; next cycle is RUN so a bare hazard stalls again
    do_reset();
    load_use_rs1_x5(); ex_redirect = 1; #1;
    chk("rd_pcsel",  {31'd0, pc_sel}, 32'd1);
    chk("rd_flush",  {30'd0, id_flush, ex_flush}, 32'd3);
    chk("rd_pcen",   {31'd0, pc_en}, 32'd1);
    step(); ex_redirect = 0; #1;
    chk("rd_cnt",    stall_count, 32'd0);
    chk("rd_run_en", {28'd0, ens()}, 32'h3);
    step(); idle(); #1;
    chk("rd_cnt2",   stall_count, 32'd1);

    // rs2 load-use; unused source and x0 never stall
    step(); ex_is_load = 1; ex_reg_write = 1; ex_rd = 5'd9; id_rs2 = 5'd9; id_uses_rs2 = 1; #1;
    chk("lu2_en",    {28'd0, ens()}, 32'h3);
    step(); idle(); step();
    ex_is_load = 1; ex_reg_write = 1; ex_rd = 5'd9; id_rs2 = 5'd9; id_uses_rs2 = 0; #1;
    chk("nouse_en",  {28'd0, ens()}, 32'hF);
    step(); ex_is_load = 1; ex_reg_write = 1; ex_rd = 5'd0; id_rs1 = 5'd0; id_uses_rs1 = 1; #1;
    chk("x0_en",     {28'd0, ens()}, 32'hF);

    // Memory freeze: 3 cycles without ack, redirect honoured on ack
    do_reset();
    dmem_req = 1; #1;
    chk("mw_en1",    {28'd0, ens()}, 32'h0);
    chk("mw_flush",  {29'd0, pc_sel, id_flush, ex_flush}, 32'd0);
    step(); #1;
    chk("mw_en2",    {28'd0, ens()}, 32'h0);
    step(); #1;
    chk("mw_en3",    {28'd0, ens()}, 32'h0);
    step(); dmem_ack = 1; ex_redirect = 1; #1;
    chk("mw_ack_en", {28'd0, ens()}, 32'hF);
    chk("mw_ack_ps", {31'd0, pc_sel}, 32'd1);
    chk("mw_cnt",    stall_count, 32'd3);
    step(); idle(); #1;
    chk("mw_run_en", {28'd0, ens()}, 32'hF);
    chk("mw_cnt2",   stall_count, 32'd3);
    step(); dmem_req = 1; dmem_ack = 1; #1;
    chk("mw_fast",   {28'd0, ens()}, 32'hF);
    step(); idle(); #1;
    chk("mw_fastc",  stall_count, 32'd3);

    // Forwarding on rs2
    step();
    ex_rd = 5'd7; ex_reg_write = 1; wb_rd = 5'd7; wb_reg_write = 1;
    id_rs2 = 5'd7; id_rs1 = 5'd3; #1;
    chk("fw_b_ex",   {30'd0, fwd_b}, 32'd1);
    chk("fw_a_rf",   {30'd0, fwd_a}, 32'd0);
    ex_reg_write = 0; #1;
    chk("fw_b_wb",   {30'd0, fwd_b}, 32'd2);
    ex_reg_write = 1; ex_rd = 5'd0; wb_rd = 5'd0; id_rs2 = 5'd0; #1;
    chk("fw_b_x0",   {30'd0, fwd_b}, 32'd0);

    // Halt
    do_reset();
    tohost_we = 1; tohost_data = 32'd0;
    step(); tohost_we = 0; #1;
    chk("h0_halted", {31'd0, halted}, 32'd0);
    chk("h0_en",     {28'd0, ens()}, 32'hF);
    tohost_we = 1; tohost_data = 32'd1; #1;
    chk("h1_pre",    {31'd0, halted}, 32'd0);
    step(); idle(); #1;
    chk("h1_halted", {31'd0, halted}, 32'd1);
    chk("h1_en",     {28'd0, ens()}, 32'h0);
    step(); #1;
    chk("h1_hold",   {31'd0, halted}, 32'd1);
    chk("h1_cnt",    stall_count, 32'd0);
    do_reset(); #1;
    chk("h_rst",     {31'd0, halted}, 32'd0);
    chk("h_rst_en",  {28'd0, ens()}, 32'hF);

    // Reset in the middle of MEM_WAIT
    step(); dmem_req = 1;
    step(); #1;
    chk("mr_en",     {28'd0, ens()}, 32'h0);
    chk("mr_cnt",    stall_count, 32'd1);
    do_reset(); #1;
    chk("mr_rst_en", {28'd0, ens()}, 32'hF);
    chk("mr_rst_c",  stall_count, 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Parameter: REG_AW, 5, register-address width.
REQ-002 Parameter: CNT_W, 32, width of the stall counter.
REQ-003 clk  in  1  sole clock; all state updates on posedge clk.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 id_rs1, id_rs2  in  REG_AW each  source registers of the instruction in ID.
REQ-006 id_uses_rs1, id_uses_rs2  in  1 each  source actually read.
REQ-007 ex_rd  in  REG_AW; ex_reg_write  in  1; ex_is_load  in  1: destination info for the instruction in EX.
REQ-008 wb_rd  in  REG_AW; wb_reg_write  in  1: destination info for the instruction in WB.
REQ-009 ex_redirect  in  1  taken branch or jump resolved in EX.
REQ-010 dmem_req  in  1; dmem_ack  in  1: data-memory handshake for the instruction in EX.
REQ-011 tohost_we  in  1; tohost_data  in  32: CSR tohost write from WB.
REQ-012 pc_en, id_en, ex_en, wb_en  out  1 each  pipeline-register load enables.
REQ-013 id_flush, ex_flush  out  1 each  insert bubble (zero control) into ID / EX register.
REQ-014 pc_sel  out  1  1 selects the redirect target for the PC.
REQ-015 fwd_a, fwd_b  out  2 each  operand select: 00 RF, 01 EX result, 10 WB result.
REQ-016 halted  out  1; stall_count  out  CNT_W: halt flag; count of stalled cycles.

Function
REQ-017 FSM states: RUN, LOAD_STALL, MEM_WAIT, HALT; outputs are combinational from state and current inputs.
REQ-018 Event priority, highest first: HALT, memory freeze, redirect, load-use.
REQ-019 RUN, no event: all enables 1, flushes 0, pc_sel 0.
REQ-020 Load-use: ex_is_load & ex_reg_write & ex_rd!=0 & (ex_rd==id_rs1 & id_uses_rs1 | ex_rd==id_rs2 & id_uses_rs2) in RUN -> pc_en=id_en=0, ex_flush=1 the same cycle; next state LOAD_STALL.
REQ-021 LOAD_STALL: lasts exactly one cycle, all enables 1, returns to RUN; no second bubble for the same load.
REQ-022 Redirect: ex_redirect in RUN -> pc_sel=1, id_flush=1, ex_flush=1 for one cycle; overrides load-use (no stall, no LOAD_STALL entry).
REQ-023 Memory freeze: dmem_req & !dmem_ack -> all enables 0, flushes 0, pc_sel 0; enter MEM_WAIT next cycle.
REQ-024 MEM_WAIT: stays while !dmem_ack with all enables 0; on dmem_ack, enables 1 that cycle and next state RUN; a redirect pending in the frozen EX is honoured in the ack cycle.
REQ-025 dmem_req & dmem_ack in the same cycle -> zero stall cycles.
REQ-026 Halt: tohost_we & tohost_data!=0 -> HALT next cycle; tohost_we with data 0 has no effect.
REQ-027 HALT: all enables 0, flushes 0, halted=1; leaves only on rst.
REQ-028 Forwarding for rs1 and for rs2 independently: 01 if ex_reg_write & ex_rd!=0 & ex_rd==rs & !ex_is_load; else 10 if wb_reg_write & wb_rd!=0 & wb_rd==rs; else 00. The EX match has priority over the WB match.
REQ-029 Register x0 never forwards and never stalls.
REQ-030 stall_count increments by 1 each cycle with pc_en==0 and state!=HALT; saturates at all-ones and does not wrap.

Reset
REQ-031 rst sampled at posedge: state=RUN, stall_count=0, halted=0.
REQ-032 Reset takes effect from any state, including mid-MEM_WAIT or HALT; the first post-reset cycle has all enables 1, flushes 0, pc_sel 0.

Structure
REQ-033 State enum and the FWD_RF, FWD_EX and FWD_WB constants live in shared package pipe_ctrl_pkg.
REQ-034 Forwarding compare logic is one combinational sub-module, pipe_fwd_unit, instantiated once per operand.

Verification
REQ-035 Load to x5 in EX, ID reads x5 via rs1 -> one cycle pc_en=0 and ex_flush=1; next cycle fwd_a=10; stall_count=1.
REQ-036 ex_redirect=1 with a simultaneous load-use hazard -> pc_sel=1, id_flush=ex_flush=1, pc_en=1; stall_count unchanged.
REQ-037 dmem_req=1, dmem_ack low for 3 cycles then high -> enables 0 for 3 cycles, 1 on the ack cycle; stall_count=3.
REQ-038 EX writes x7 (non-load), WB writes x7, ID rs2=x7 -> fwd_b=01; with ex_rd=0 and wb_rd=0 -> fwd_b=00.
REQ-039 tohost_we=1 with data=0 -> no halt; with data=1 -> halted=1 next cycle and held; rst=1 -> halted=0 and state RUN.
REQ-040 rst asserted during MEM_WAIT -> next cycle all enables 1 and stall_count=0.
